next_pc_unit: RTL and testbench
===============================

// Module: next_pc_unit
// PURPOSE
// - Owns the program counter of the single-cycle core: holds PC, computes PC+4, branch, jump and
//   jump-register targets, and selects the next PC by fixed priority.
// - Generalises jump-address composition to any address width and region size. Adds stall, exception
//   redirect and an optional MIPS-style branch-delay-slot mode that defers a redirect by one instruction.
// - Sits between instruction memory (pc out) and control/decoder (redirect requests in).
// PARAMETERS
// - ADDR_W      32            PC / address width in bits (>= REGION_W+18)
// - REGION_W    4             upper PC+4 bits kept on J-type jump
// - RESET_PC    32'h0000_3000 PC value after reset (low 2 bits must be 0)
// - EXC_VECTOR  32'h0000_4180 PC loaded on exception
// - DELAY_SLOT  0             0: redirect takes effect next cycle; 1: one delay-slot instruction first
// - localparam JIDX_W = ADDR_W-REGION_W-2 (26 at defaults)
// PORTS
// - clk          in   1        rising-edge clock
// - rst_n        in   1        synchronous reset, active low
// - stall        in   1        hold PC and pending state this cycle
// - take_branch  in   1        conditional branch resolved taken
// - branch_off   in   16       signed word offset of branch
// - jump         in   1        J-type jump
// - jump_index   in   JIDX_W   J-type word index field
// - jump_reg     in   1        register-indirect jump
// - reg_target   in   ADDR_W   register jump target
// - exc          in   1        exception / trap request
// - pc           out  ADDR_W   current PC (registered)
// - pc4          out  ADDR_W   pc + 4 (combinational)
// - redirect_pending out 1     delay-slot target latched, not yet applied (registered)
// - jr_misalign  out  1        one-cycle pulse: accepted jump_reg had reg_target[1:0] != 0
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge): pc<=RESET_PC, pending cleared, redirect_pending<=0, jr_misalign<=0.
//   Reset wins over every other input, including mid-delay-slot.
// - Target arithmetic, all modulo 2^ADDR_W:
//   pc4 = pc+4; br_tgt = pc4 + (sext(branch_off)<<2); j_tgt = {pc4[ADDR_W-1 -: REGION_W], jump_index, 2'b00};
//   jr_tgt = {reg_target[ADDR_W-1:2], 2'b00} (low bits forced to 0, jr_misalign raised next cycle).
// - Priority of redirect sources: exc > jump_reg > jump > take_branch > sequential (pc4).
// - exc is honoured even when stall=1: pc<=EXC_VECTOR, pending cleared.
// - stall=1 and exc=0: pc, pending and redirect_pending hold; redirect inputs ignored; jr_misalign<=0.
// - DELAY_SLOT=0: every non-stalled cycle pc<=selected target; redirect_pending is constantly 0.
// - DELAY_SLOT=1: two-state FSM IDLE / PEND.
//   IDLE: redirect seen -> pend_tgt<=target, pc<=pc4, go PEND; no redirect -> pc<=pc4.
//   PEND: pc<=pend_tgt, go IDLE. Redirect inputs in PEND (branch in delay slot) are ignored.
//   redirect_pending=1 exactly while in PEND.
// - jr_misalign is registered, asserted the cycle after a non-stalled, accepted jump_reg with
//   misaligned target; otherwise 0. It is ignored in PEND and when exc wins.
// - Latency: pc updates one clock after inputs are sampled; pc4 follows pc combinationally.
// STRUCTURE
// - Shared package pc_pkg: RESET_PC/EXC_VECTOR defaults, next-PC select encoding
//   (SEL_SEQ, SEL_BR, SEL_J, SEL_JR, SEL_EXC) and the FSM state encoding.
// - One sub-module: jump_target_gen (combinational: pc4, branch_off, jump_index, reg_target -> br/j/jr
//   targets, misalign flag). The parent holds the PC register, priority mux and delay-slot FSM.
// TESTING
// - Reset then 3 free cycles -> pc = 3000, 3004, 3008; redirect_pending = 0.
// - DELAY_SLOT=0, pc=3008, jump=1, jump_index=26'h0000C40 -> next pc=0000_3100.
//   Same cycle with take_branch=1 -> jump still wins.
// - Branch with branch_off=16'hFFFF at pc=3010 -> next pc=3010. At pc=FFFF_FFFC, offset 0 -> pc wraps to 0.
// - DELAY_SLOT=1, pc=3000, take_branch, branch_off=4 -> 3004 with pending=1, then 3014 with pending=0.
//   A branch asserted during PEND is ignored.
// - stall=1 for 2 cycles during PEND -> pc and pending hold. exc during stall -> pc=4180, pending=0.
// - jump_reg, reg_target=0000_2002 -> pc=2000 and jr_misalign pulses 1 cycle.
//   rst_n=0 mid-PEND -> pc=3000, pending=0.

Source files
------------

// File: rtl/pc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pc_pkg: shared constants and encodings for the next-PC unit        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package pc_pkg;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;

    typedef enum logic [2:0] {
        SEL_SEQ = 3'd0,
        SEL_BR  = 3'd1,
        SEL_J   = 3'd2,
        SEL_JR  = 3'd3,
        SEL_EXC = 3'd4
    } sel_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } ds_state_t;

endpackage
`default_nettype wire

// File: rtl/jump_target_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jump_target_gen: branch / jump / jump-register target arithmetic   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module jump_target_gen #(
    parameter int ADDR_W   = 32,
    parameter int REGION_W = 4,
    parameter int JIDX_W   = ADDR_W - REGION_W - 2
) (
    input  logic [ADDR_W-1:0] pc4,
    input  logic [15:0]       branch_off,
    input  logic [JIDX_W-1:0] jump_index,
    input  logic [ADDR_W-1:0] reg_target,
    output logic [ADDR_W-1:0] br_tgt,
    output logic [ADDR_W-1:0] j_tgt,
    output logic [ADDR_W-1:0] jr_tgt,
    output logic              jr_misalign
);

    logic [ADDR_W-1:0] w_br_off;

    // Word offset scaled to bytes, then sign-extended to the address width
    assign w_br_off    = ADDR_W'($signed({branch_off, 2'b00}));
    assign br_tgt      = pc4 + w_br_off;
    assign j_tgt       = {pc4[ADDR_W-1 -: REGION_W], jump_index, 2'b00};
    assign jr_tgt      = {reg_target[ADDR_W-1:2], 2'b00};
    assign jr_misalign = |reg_target[1:0];

endmodule
`default_nettype wire

// File: rtl/next_pc_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | next_pc_unit: PC register, priority next-PC select, delay-slot FSM |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module next_pc_unit
    import pc_pkg::*;
#(
    parameter int              ADDR_W     = 32,
    parameter int              REGION_W   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEF_RESET_PC),
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEF_EXC_VECTOR),
    parameter bit              DELAY_SLOT = 1'b0,
    localparam int             JIDX_W     = ADDR_W - REGION_W - 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              take_branch,
    input  logic [15:0]       branch_off,
    input  logic              jump,
    input  logic [JIDX_W-1:0] jump_index,
    input  logic              jump_reg,
    input  logic [ADDR_W-1:0] reg_target,
    input  logic              exc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc4,
    output logic              redirect_pending,
    output logic              jr_misalign
);

    logic [ADDR_W-1:0] r_pc, r_pend_tgt;
    logic              r_misalign;
    ds_state_t         r_state;

    logic [ADDR_W-1:0] w_pc4, w_br_tgt, w_j_tgt, w_jr_tgt, w_tgt;
    logic [ADDR_W-1:0] w_pc_next, w_pend_next;
    logic              w_jr_mis, w_misalign_next;
    ds_state_t         w_state_next;
    sel_t              w_sel;

    assign w_pc4 = r_pc + ADDR_W'(4);

    jump_target_gen #(
        .ADDR_W   (ADDR_W),
        .REGION_W (REGION_W),
        .JIDX_W   (JIDX_W)
    ) u_tgt (
        .pc4         (w_pc4),
        .branch_off  (branch_off),
        .jump_index  (jump_index),
        .reg_target  (reg_target),
        .br_tgt      (w_br_tgt),
        .j_tgt       (w_j_tgt),
        .jr_tgt      (w_jr_tgt),
        .jr_misalign (w_jr_mis)
    );

    always_comb begin
        w_sel = SEL_SEQ;
        if (exc)              w_sel = SEL_EXC;
        else if (jump_reg)    w_sel = SEL_JR;
        else if (jump)        w_sel = SEL_J;
        else if (take_branch) w_sel = SEL_BR;
    end

    always_comb begin
        w_tgt = w_pc4;
        case (w_sel)
            SEL_BR:  w_tgt = w_br_tgt;
            SEL_J:   w_tgt = w_j_tgt;
            SEL_JR:  w_tgt = w_jr_tgt;
            SEL_EXC: w_tgt = EXC_VECTOR;
            default: w_tgt = w_pc4;
        endcase
    end

    // Exception overrides stall; in PEND the latched target is applied and new redirects dropped
    always_comb begin
        w_pc_next       = r_pc;
        w_pend_next     = r_pend_tgt;
        w_state_next    = r_state;
        w_misalign_next = 1'b0;
        if (exc) begin
            w_pc_next    = EXC_VECTOR;
            w_pend_next  = '0;
            w_state_next = ST_IDLE;
        end else if (!stall) begin
            if (DELAY_SLOT == 1'b0) begin
                w_pc_next       = w_tgt;
                w_misalign_next = jump_reg & w_jr_mis;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        w_pc_next = w_pc4;
                        if (w_sel != SEL_SEQ) begin
                            w_pend_next     = w_tgt;
                            w_state_next    = ST_PEND;
                            w_misalign_next = jump_reg & w_jr_mis;
                        end
                    end
                    ST_PEND: begin
                        w_pc_next    = r_pend_tgt;
                        w_state_next = ST_IDLE;
                    end
                    default: w_state_next = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_pend_tgt <= '0;
            r_state    <= ST_IDLE;
            r_misalign <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_pend_tgt <= w_pend_next;
            r_state    <= w_state_next;
            r_misalign <= w_misalign_next;
        end
    end

    assign pc               = r_pc;
    assign pc4              = w_pc4;
    assign redirect_pending = (r_state == ST_PEND);
    assign jr_misalign      = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_next_pc_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_next_pc_unit: scoreboard bench, both delay-slot modes in parallel|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_next_pc_unit;

    typedef struct {
        logic [31:0] pc;
        bit          pend;
        bit          mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, stall, take_branch, jump, jump_reg, exc;
    logic [15:0] branch_off;
    logic [25:0] jump_index;
    logic [31:0] reg_target;
    logic [31:0] pc0, pc4_0, pc1, pc4_1;
    logic        pend0, pend1, mis0, mis1;

    int   n_tests = 0;
    int   n_fail  = 0;
    bit   done    = 1'b0;
    exp_t q0[$];
    exp_t q1[$];

    logic [31:0] m_pc[2];
    bit          m_pend[2];
    logic [31:0] m_ptgt[2];

    always #5 clk = ~clk;

    next_pc_unit #(.DELAY_SLOT(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .take_branch(take_branch),
        .branch_off(branch_off), .jump(jump), .jump_index(jump_index),
        .jump_reg(jump_reg), .reg_target(reg_target), .exc(exc),
        .pc(pc0), .pc4(pc4_0), .redirect_pending(pend0), .jr_misalign(mis0)
    );

    next_pc_unit #(.DELAY_SLOT(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .stall(stall), .take_branch(take_branch),
        .branch_off(branch_off), .jump(jump), .jump_index(jump_index),
        .jump_reg(jump_reg), .reg_target(reg_target), .exc(exc),
        .pc(pc1), .pc4(pc4_1), .redirect_pending(pend1), .jr_misalign(mis1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: what the PC should be after this cycle's edge, from the architectural rules
    task automatic model(input int d);
        logic [31:0] seq, tgt;
        int          off_bytes;
        bit          mis;
        exp_t        e;
        seq       = m_pc[d] + 32'd4;
        off_bytes = int'($signed(branch_off)) * 4;
        mis       = 1'b0;
        if (jump_reg)         tgt = reg_target & 32'hFFFF_FFFC;
        else if (jump)        tgt = (seq & 32'hF000_0000) | (32'(jump_index) * 4);
        else if (take_branch) tgt = seq + 32'(off_bytes);
        else                  tgt = seq;
        if (!rst_n) begin
            m_pc[d] = 32'h0000_3000; m_pend[d] = 1'b0;
        end else if (exc) begin
            m_pc[d] = 32'h0000_4180; m_pend[d] = 1'b0;
        end else if (stall) begin
            mis = 1'b0;
        end else if (d == 0) begin
            m_pc[d] = tgt;
            mis     = jump_reg && (reg_target % 4 != 0);
        end else if (m_pend[d]) begin
            m_pc[d] = m_ptgt[d]; m_pend[d] = 1'b0;
        end else begin
            if (jump_reg || jump || take_branch) begin
                m_ptgt[d] = tgt; m_pend[d] = 1'b1;
                mis       = jump_reg && (reg_target % 4 != 0);
            end
            m_pc[d] = seq;
        end
        e.pc = m_pc[d]; e.pend = m_pend[d]; e.mis = mis;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic cyc(input bit r, input bit s, input bit b, input logic [15:0] off,
                       input bit j, input logic [25:0] idx, input bit jr,
                       input logic [31:0] rt, input bit e);
        rst_n = r; stall = s; take_branch = b; branch_off = off; jump = j;
        jump_index = idx; jump_reg = jr; reg_target = rt; exc = e;
        model(0);
        model(1);
        @(negedge clk);
    endtask

    task automatic cmp(input string tag, input exp_t e, input logic [31:0] p,
                       input logic [31:0] p4, input logic pd, input logic ms);
        n_tests++;
        if (p !== e.pc || p4 !== e.pc + 32'd4 || pd !== e.pend || ms !== e.mis) begin
            n_fail++;
            $display("FAIL %s: got pc=%h pc4=%h pend=%b mis=%b, expected pc=%h pc4=%h pend=%b mis=%b",
                     tag, p, p4, pd, ms, e.pc, e.pc + 32'd4, e.pend, e.mis);
        end
    endtask

    // Monitor: every edge the DUTs present a new PC; pop and compare
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) begin e = q0.pop_front(); cmp("ds0", e, pc0, pc4_0, pend0, mis0); end
            if (q1.size() > 0) begin e = q1.pop_front(); cmp("ds1", e, pc1, pc4_1, pend1, mis1); end
        end
    end

    initial begin
        m_pc[0] = '0; m_pc[1] = '0; m_pend[0] = 0; m_pend[1] = 0; m_ptgt[0] = '0; m_ptgt[1] = '0;
        // directed scenarios
        cyc(0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);
        cyc(1, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);
        cyc(1, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);
        chk("free_run_pc", pc0, 32'h0000_3008);
        cyc(1, 0, 1, 16'h0010, 1, 26'h0000C40, 0, 32'h0, 0);
        chk("jump_over_branch", pc0, 32'h0000_3100);
        cyc(1, 0, 0, 16'h0, 1, 26'h0000C04, 0, 32'h0, 0);
        cyc(1, 0, 1, 16'hFFFF, 0, 26'h0, 0, 32'h0, 0);
        chk("branch_minus1", pc0, 32'h0000_3010);
        cyc(1, 0, 0, 16'h0, 0, 26'h0, 1, 32'hFFFF_FFFC, 0);
        cyc(1, 0, 1, 16'h0000, 0, 26'h0, 0, 32'h0, 0);
        chk("wrap_to_zero", pc0, 32'h0000_0000);
        cyc(1, 0, 0, 16'h0, 0, 26'h0, 1, 32'h0000_2002, 0);
        chk("jr_aligned_pc", pc0, 32'h0000_2000);
        chk("jr_misalign", {31'h0, mis0}, 32'h1);
        cyc(0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);
        cyc(1, 0, 1, 16'h0004, 0, 26'h0, 0, 32'h0, 0);
        chk("ds_slot_pc", {pc1[31:1], pend1}, {31'h0000_3004 >> 1, 1'b1});
        cyc(1, 0, 1, 16'h0004, 0, 26'h0, 0, 32'h0, 0);
        chk("ds_target_pc", {pc1[31:1], pend1}, {31'h0000_3014 >> 1, 1'b0});
        cyc(1, 0, 1, 16'h0008, 0, 26'h0, 0, 32'h0, 0);
        cyc(1, 1, 1, 16'h0100, 0, 26'h0, 0, 32'h0, 0);
        cyc(1, 1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);
        chk("ds_stall_hold", {pc1[31:1], pend1}, {31'h0000_3018 >> 1, 1'b1});
        cyc(1, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);
        chk("ds_after_stall", pc1, 32'h0000_3038);
        cyc(1, 0, 1, 16'h0008, 0, 26'h0, 0, 32'h0, 0);
        cyc(1, 1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 1);
        chk("exc_in_stall", {pc1[31:1], pend1}, {31'h0000_4180 >> 1, 1'b0});
        cyc(1, 0, 1, 16'h0008, 0, 26'h0, 0, 32'h0, 0);
        cyc(0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);
        chk("reset_mid_pend", {pc1[31:1], pend1}, {31'h0000_3000 >> 1, 1'b0});

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] rt;
            rt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 3) == 0), 16'($urandom),
                ($urandom_range(0, 5) == 0), 26'($urandom),
                ($urandom_range(0, 6) == 0), rt,
                ($urandom_range(0, 24) == 0));
        end
        @(negedge clk);
        done = 1'b1;
    end

    initial begin
        fork
            wait (done);
            begin
                #200000;
                n_tests++;
                n_fail++;
                $display("FAIL timeout: stimulus did not complete, got done=0, expected done=1");
            end
        join_any
        n_tests++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d/%0d left, expected 0/0", q0.size(), q1.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
